// File: rtl/counter8_rr_scheduler.sv
// Shared-incrementer scheduler: NUM_REQ event counters share one WIDTH-bit
// incrementer, which a round-robin arbiter grants to one requester per cycle.
module counter8_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     en,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       clr,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       wrap,
   output logic [NUM_REQ*WIDTH-1:0] count,
   output logic                     busy
);

   localparam int LW = $clog2(NUM_REQ);

   // Handshake: a requester holds req[i] until it samples gnt[i]=1; the grant
   // cycle consumes one increment, and keeping req high asks for another.

   logic [WIDTH-1:0]   r_cnt [NUM_REQ];
   logic [LW-1:0]      r_last;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_wrap;
   logic               r_busy;

   logic [NUM_REQ-1:0] w_elig;
   logic               w_found;
   logic [LW-1:0]      w_win;
   int                 w_idx;
   logic [NUM_REQ-1:0] w_onehot;
   logic [WIDTH-1:0]   w_old;
   logic [WIDTH-1:0]   w_inc;
   logic               w_rollover;

   // A cleared channel is masked so its pending request survives the clear.
   always_comb begin
      w_elig  = req & ~clr & {NUM_REQ{en}};
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = (int'(r_last) + k) % NUM_REQ;
         if (!w_found && w_elig[w_idx]) begin
            w_found = 1'b1;
            w_win   = LW'(w_idx);
         end
      end
   end

   always_comb begin
      w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
      w_old      = r_cnt[w_win];
      w_inc      = w_old + {{(WIDTH-1){1'b0}}, 1'b1};
      w_rollover = (w_old == {WIDTH{1'b1}});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
         r_last <= LW'(NUM_REQ - 1);
         r_gnt  <= '0;
         r_wrap <= '0;
         r_busy <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (clr[i])
               r_cnt[i] <= '0;
            else if (w_found && (w_win == LW'(i)))
               r_cnt[i] <= w_inc;
         end
         r_gnt  <= w_found ? w_onehot : '0;
         r_wrap <= (w_found && w_rollover) ? w_onehot : '0;
         r_busy <= w_found;
         if (w_found) r_last <= w_win;
      end
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_REQ; i++) count[i*WIDTH +: WIDTH] = r_cnt[i];
   end

   assign gnt  = r_gnt;
   assign wrap = r_wrap;
   assign busy = r_busy;

endmodule

// File: doc/counter8_rr_scheduler.md
# counter8_rr_scheduler

Shared-incrementer scheduler for a bank of 8-bit event counters. Up to eight requesters each own a counter register, but all increments go through a single WIDTH-bit incrementer. A round-robin arbiter grants that incrementer to one requester per cycle. The block sits between event sources and the counter bank, and replaces per-channel free-running counters where area matters.

## Interface
- NUM_REQ, default 4: number of requesters/counters; legal range 2..8.
- WIDTH, default 8: counter width in bits.
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  scheduler enable; when low, no grants are issued and counts hold.
- req  input  NUM_REQ  per-channel increment request; level, held until granted.
- clr  input  NUM_REQ  per-channel synchronous clear of the counter.
- gnt  output  NUM_REQ  registered one-hot grant; high for the cycle after the edge that performed the increment.
- wrap  output  NUM_REQ  registered one-cycle pulse; the granted counter rolled over from all-ones to zero.
- count  output  NUM_REQ*WIDTH  counter values, flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- busy  output  1  registered; high when any grant was issued at the last edge.

## Operation
- State: NUM_REQ counters, round-robin pointer `last` (index of last winner), gnt/wrap/busy registers.
- Eligibility at each rising edge: channel i is eligible if req[i]=1, clr[i]=0 and en=1.
- Arbitration: the winner is the first eligible channel searching last+1, last+2, … modulo NUM_REQ. If nothing is eligible, there is no winner.
- With a winner w:
  - count[w] <= count[w]+1, modulo 2^WIDTH.
  - gnt <= onehot(w); busy <= 1; last <= w.
  - wrap[w] <= 1 only if old count[w] was 2^WIDTH-1; all other wrap bits are 0.
- Without a winner: gnt <= 0, wrap <= 0, busy <= 0, and last holds.
- Clear:
  - clr[i]=1 sets count[i] <= 0 at the edge, regardless of en.
  - Clear has priority over increment. A cleared channel is masked from arbitration that cycle, so its request stays pending and no event is lost or double-counted.
- Handshake: the requester keeps req high until it samples gnt[i]=1.
  - Clearing req in the same cycle gnt is seen consumes exactly one increment.
  - Leaving req high requests another increment.
- Multiple clr bits may be active at once; each clears independently.
- en low: all arbitration is suspended and last holds. Clears still act.

## Timing
- Reset (reset_n=0, asynchronous): all counts 0, gnt 0, wrap 0, busy 0, last = NUM_REQ-1. Channel 0 therefore has first priority after reset.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. A pending grant is dropped, so the requester must re-request after release.
- Latency: req sampled high at edge N. The count updates at edge N, and gnt is visible after edge N for one cycle.
- Throughput: one increment per cycle total. When all NUM_REQ channels request continuously, each is granted exactly once every NUM_REQ cycles.
- Fairness: a continuously requesting channel waits at most NUM_REQ-1 cycles for a grant, excluding cycles with en=0 or its own clr=1.
- Wrap: from count 2^WIDTH-1, a grant yields count 0 and wrap pulse together with gnt. For WIDTH=8: 255 -> 0 with wrap=1.
- Outputs are registered only; there is no combinational path from req, clr or en to any output.

## Test plan
- Reset/priority: release reset with req=4'b1111 held, en=1 → grants in order 0,1,2,3,0,…; after 8 edges every count=2, busy=1 throughout.
- Single channel/handshake: req[2] pulsed high, then dropped when gnt[2] seen → exactly one grant; count[2]=1, others 0, busy returns to 0.
- Wrap: 256 grants to channel 1 → after grant 255, count[1]=255, wrap=0; grant 256 gives count[1]=0 and wrap[1]=1 for one cycle.
- Clear collision: channel 0 at count 5 with req[0]=1, clr[0]=1 for one edge → count[0]=0, no gnt[0]; next edge grants it, count[0]=1. Channel 1, requesting in the same cycle, is granted instead.
- Enable gating: all req high, en dropped for 3 cycles → gnt=0, counts frozen. On re-enable, arbitration resumes from the channel after the last winner.
- Async reset mid-stream: assert reset_n low between edges during continuous grants → count/gnt/wrap/busy go to 0 immediately. After release, channel 0 is granted first.
